// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the registered N-to-1 mux/arbiter.
// Optional transfer counter width lives here as well (used with MUX_ARB_COUNT_EN).
package mux_arb_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    localparam int   COUNT_W     = 16;

    // Round-robin pointer advance: the channel after the winner, wrapping to 0.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned channels);
        if (idx == channels - 32'd1) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic                found_o,
    output logic [SEL_W-1:0]    idx_o
);

    // Walk the channels starting at the pointer; the first requester wins.
    always_comb begin
        int unsigned        k;
        logic [SEL_W-1:0]   k_idx;
        found_o = 1'b0;
        idx_o   = '0;
        k       = 32'd0;
        k_idx   = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            k = 32'(ptr_i) + 32'(off);
            if (k >= 32'(CHANNELS)) begin
                k = k - 32'(CHANNELS);
            end else begin
                k = k;
            end
            k_idx = SEL_W'(k);
            if (!found_o && req_i[k_idx]) begin
                found_o = 1'b1;
                idx_o   = k_idx;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 mux with valid/ready on every channel; explicit select or round-robin.
// Defining MUX_ARB_COUNT_EN adds count_o, a saturating count of input transfers.
module mux_arb_nto1
    import mux_arb_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [CHANNELS-1:0]       valid_i,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    output logic [CHANNELS-1:0]       ready_o,
    output logic [WIDTH-1:0]          data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [SEL_W-1:0]          grant_o
`ifdef MUX_ARB_COUNT_EN
    ,
    output logic [COUNT_W-1:0]        count_o
`endif
);

    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SEL_W-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;

    logic                 out_free_s;
    logic                 rr_found_s;
    logic [SEL_W-1:0]     rr_idx_s;
    logic                 cand_found_s;
    logic [SEL_W-1:0]     cand_idx_s;
    logic                 in_xfer_s;
    logic [WIDTH-1:0]     pick_data_s;

    assign out_free_s = !valid_q || ready_i;

    mux_arb_rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req_i   (valid_i),
        .ptr_i   (ptr_q),
        .found_o (rr_found_s),
        .idx_o   (rr_idx_s)
    );

    // Candidate channel: sel_i in select mode (unused codes grant nothing), picker in RR mode.
    always_comb begin
        if (mode_i == MODE_RR) begin
            cand_found_s = rr_found_s;
            cand_idx_s   = rr_idx_s;
        end else begin
            cand_found_s = (32'(sel_i) < 32'(CHANNELS));
            cand_idx_s   = sel_i;
        end
    end

    assign in_xfer_s = cand_found_s && valid_i[cand_idx_s] && out_free_s;

    // Payload of the candidate channel.
    always_comb begin
        pick_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cand_idx_s == SEL_W'(k)) begin
                pick_data_s = data_i[k*WIDTH +: WIDTH];
            end else begin
                pick_data_s = pick_data_s;
            end
        end
    end

    // One-hot accept toward the candidate whenever the output slot can take a word.
    always_comb begin
        ready_o = '0;
        if (cand_found_s && out_free_s) begin
            ready_o[cand_idx_s] = 1'b1;
        end else begin
            ready_o = '0;
        end
    end

    // Output register next state; load and drain in the same cycle gives no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (in_xfer_s) begin
            valid_d = 1'b1;
            data_d  = pick_data_s;
            grant_d = cand_idx_s;
            if (mode_i == MODE_RR) begin
                ptr_d = SEL_W'(next_ptr(32'(cand_idx_s), 32'(CHANNELS)));
            end else begin
                ptr_d = ptr_q;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign grant_o = grant_q;

`ifdef MUX_ARB_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Transfer counter sticks at all-ones instead of wrapping.
    always_comb begin
        if (in_xfer_s && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
`endif

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Registered N-to-1 multiplexer with a valid/ready handshake on each input channel and on the output. The successor to the combinational 2:1 datapath mux.
- Two run-time modes:
  - explicit select, as driven by control logic;
  - round-robin arbitration among requesting channels.
- Used where several producers share one registered datapath, e.g. writeback sources or memory request ports in the next CPU revision.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), localparam, width of select/grant fields. Not overridable.

Ports:
- clk_i  input  1  sole clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- mode_i  input  1  0 = select mode, 1 = round-robin mode.
- sel_i  input  SEL_W  channel index used in select mode.
- valid_i  input  CHANNELS  per-channel request; bit k belongs to channel k.
- data_i  input  CHANNELS*WIDTH  packed payloads; channel k occupies bits [k*WIDTH +: WIDTH].
- ready_o  output  CHANNELS  per-channel accept; at most one bit high.
- data_o  output  WIDTH  registered output payload.
- valid_o  output  1  output register holds valid data.
- ready_i  input  1  downstream accept.
- grant_o  output  SEL_W  registered index of the channel whose data sits in data_o.

Behaviour:
- Reset (async assert, sync release): valid_o=0, data_o=0, grant_o=0, RR pointer ptr=0. Optional count_o=0.
- Output slot free: out_free = !valid_o | ready_i.
- Candidate channel g:
  - Select mode: g = sel_i. No candidate if sel_i >= CHANNELS.
  - RR mode: first k with valid_i[k]=1, searching ptr, ptr+1, … CHANNELS-1, 0, … ptr-1 (wrap). No candidate if valid_i is all zero.
- ready_o[g] = out_free when a candidate exists. All other ready_o bits are 0, and all are 0 when there is no candidate.
  - ready_o is combinational from ready_i, mode_i, sel_i, valid_i and ptr.
  - In select mode, ready_o[sel_i] may be high while valid_i[sel_i]=0.
- Input transfer: a candidate exists, valid_i[g]=1 and out_free=1. On the next edge: data_o <= channel g payload, grant_o <= g, valid_o <= 1.
- Output transfer: valid_o & ready_i. If there is no simultaneous input transfer, valid_o <= 0. data_o and grant_o hold their last values.
- Simultaneous output and input transfer: the register reloads with no bubble. Full throughput is 1 word/cycle.
- Latency: exactly 1 cycle from input transfer to valid_o.
- Stall (valid_o=1, ready_i=0): data_o, grant_o and valid_o are held stable; all ready_o are 0.
- RR pointer:
  - Updates only on an RR-mode input transfer: ptr <= (g == CHANNELS-1) ? 0 : g+1.
  - Select-mode transfers leave ptr unchanged.
- Mode switch: mode_i and sel_i are sampled combinationally and take effect in the same cycle. Already-registered output data is unaffected.
- Reset mid-stream: the pending output word is discarded (valid_o drops immediately); no handshake completes.
- CHANNELS not a power of 2: unused sel_i codes grant nothing.

Optional Feature:
- MUX_ARB_COUNT_EN defined:
  - Adds output count_o [15:0], the number of input transfers since reset.
  - Increments by 1 on each input transfer and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mux_arb_pkg:
  - MODE_SELECT=1'b0, MODE_RR=1'b1;
  - COUNT_W=16;
  - function next_ptr(idx, channels) for the wrap increment.
- Sub-module mux_arb_rr_pick: combinational pointer-based priority picker.
  - Inputs: req[CHANNELS], ptr.
  - Outputs: found, idx[SEL_W].
- Top holds the output register, handshake and pointer.

Test Plan:
- Reset: assert rst_i mid-transfer with valid_o=1 -> valid_o=0, data_o=0, grant_o=0 immediately; after release, ptr=0.
- Select mode, CHANNELS=4, sel_i=2, data_i ch2=32'hA5A5_0002, valid_i=4'b0100, ready_i=1 -> ready_o=4'b0100; next cycle data_o=32'hA5A5_0002, grant_o=2, valid_o=1.
- RR fairness: all four valid held high and ready_i=1 for 8 cycles -> grant_o sequence 0,1,2,3,0,1,2,3 on consecutive cycles, with no bubbles.
- RR skip/wrap: ptr=3, valid_i=4'b0010 -> grant 1, ptr becomes 2. Then valid_i=4'b0001 -> grant 0, ptr becomes 1.
- Backpressure: valid_o=1, ready_i=0 for 3 cycles -> ready_o=0, data_o stable. ready_i=1 with new valid -> output and input transfer in the same cycle, new word registered.
- MUX_ARB_COUNT_EN: 70000 back-to-back transfers -> count_o=16'hFFFF and holds there. Invalid sel_i=5 with CHANNELS=5 -> ready_o=0 and no increment.
